// File: rtl/dom_pkg.sv
// rtl/dom_pkg.sv - shared LFSR constants, FSM state type and single-step helper for the DOM randomness source
package dom_pkg;

    localparam int          LFSR_W        = 32;
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] FALLBACK_SEED = 32'h1;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_WARMUP,
        ST_RUN
    } gen_state_t;

    // Fibonacci step: taps 31, 21, 1, 0 fold into the new LSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_adv.sv
// rtl/lfsr_adv.sv - combinational STEPS-fold unrolling of the 32-bit Fibonacci LFSR
module lfsr_adv
    import dom_pkg::*;
#(
    parameter int STEPS = 8
) (
    input  logic [LFSR_W-1:0] i_s,
    output logic [LFSR_W-1:0] o_s
);

    always_comb begin
        o_s = i_s;
        for (int k = 0; k < STEPS; k++) begin
            o_s = lfsr_step(o_s);
        end
    end

endmodule

// File: rtl/dom_rand_gen.sv
// rtl/dom_rand_gen.sv - seeded LFSR delivering one 2-bit Z mask per DOM gadget with valid/ready and reseed request
module dom_rand_gen
    import dom_pkg::*;
#(
    parameter int N_GADGETS       = 4,
    parameter int WARMUP_WORDS    = 1,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seed_valid,
    input  logic [31:0]            seed_data,
    output logic                   seed_ready,
    output logic [2*N_GADGETS-1:0] rand_o,
    output logic                   rand_valid,
    input  logic                   rand_ready,
    output logic                   reseed_req,
    output logic                   seed_err
);

    localparam int          RW        = 2 * N_GADGETS;
    localparam logic [15:0] WARM_LAST = 16'(WARMUP_WORDS);
    localparam logic [15:0] RESEED_AT = 16'(RESEED_INTERVAL);

    gen_state_t        r_state, w_state_next;
    logic [LFSR_W-1:0] r_s, w_s_next, w_s_adv;
    logic [15:0]       r_warm_cnt, w_warm_next, w_warm_inc;
    logic [15:0]       r_word_cnt, w_word_next, w_word_inc;
    logic              r_reseed, w_reseed_next;
    logic              r_seed_err, w_seed_err_next;

    lfsr_adv #(.STEPS(RW)) u_adv (
        .i_s (r_s),
        .o_s (w_s_adv)
    );

    assign w_warm_inc = r_warm_cnt + 16'd1;
    assign w_word_inc = r_word_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNSEEDED;
            r_s        <= '0;
            r_warm_cnt <= '0;
            r_word_cnt <= '0;
            r_reseed   <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s        <= w_s_next;
            r_warm_cnt <= w_warm_next;
            r_word_cnt <= w_word_next;
            r_reseed   <= w_reseed_next;
            r_seed_err <= w_seed_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_s_next        = r_s;
        w_warm_next     = r_warm_cnt;
        w_word_next     = r_word_cnt;
        w_reseed_next   = r_reseed;
        w_seed_err_next = r_seed_err;
        seed_ready      = 1'b1;
        rand_valid      = (r_state == ST_RUN);

        // A seed always wins, even over a same-cycle rand handshake.
        if (seed_valid) begin
            w_s_next        = (seed_data == 32'h0) ? FALLBACK_SEED : seed_data;
            w_seed_err_next = (seed_data == 32'h0);
            w_word_next     = '0;
            w_reseed_next   = 1'b0;
            w_warm_next     = '0;
            w_state_next    = (WARMUP_WORDS > 0) ? ST_WARMUP : ST_RUN;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    w_s_next    = w_s_adv;
                    w_warm_next = w_warm_inc;
                    if (w_warm_inc == WARM_LAST) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rand_ready) begin
                        w_s_next = w_s_adv;
                        if (r_word_cnt != 16'hFFFF) begin
                            w_word_next = w_word_inc;
                            if (w_word_inc == RESEED_AT) begin
                                w_reseed_next = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rand_o     = r_s[RW-1:0];
    assign reseed_req = r_reseed;
    assign seed_err   = r_seed_err;

endmodule
